// File: rtl/driver_cfg_writer_pkg.sv
// driver_cfg_writer_pkg
//   Shared definitions for the config-bus writer: command opcodes, the writer
//   FSM state encoding and small decode helpers. The driver_core test
//   environment imports the same opcodes, so values here must stay stable.
package driver_cfg_writer_pkg;

  // Command opcodes (cmd_op); 5..7 are reserved.
  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_MEM_WR   = 3'd1;
  localparam logic [2:0] OP_DOT_WR   = 3'd2;
  localparam logic [2:0] OP_SEL_WR   = 3'd3;
  localparam logic [2:0] OP_SET_CTRL = 3'd4;

  // Writer FSM; explicit encodings are kept identical to the legacy values.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } wr_state_t;

  // One-hot strobe selector: bit0 mem_write, bit1 mem_dot_write, bit2 mem_sel_write.
  typedef logic [2:0] strobe_sel_t;

  function automatic logic op_is_reserved(input logic [2:0] op);
    return (op > OP_SET_CTRL);
  endfunction

  // Ops that occupy the bus timing sequence (and drop cmd_ready).
  function automatic logic op_is_timed(input logic [2:0] op);
    return (op >= OP_MEM_WR) && (op <= OP_SET_CTRL);
  endfunction

  function automatic strobe_sel_t op_strobe(input logic [2:0] op);
    strobe_sel_t s;
    s = '0;
    case (op)
      OP_MEM_WR: s = 3'b001;
      OP_DOT_WR: s = 3'b010;
      OP_SEL_WR: s = 3'b100;
      default:   s = '0;
    endcase
    return s;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/driver_cfg_writer_phase_timer.sv
// cfg_phase_timer
//   Down-counter that times one writer phase. A start pulse loads the phase
//   length; the count then decrements to 1, where done is high for exactly
//   one cycle. The owner either restarts it on that cycle (next phase) or
//   lets it run out to 0, where it idles. It never wraps.
// Ports
//   clock       in   clock_a-domain clock
//   reset       in   asynchronous, active-high reset
//   start       in   load load_value this edge
//   load_value  in   phase length in cycles (>=1)
//   done        out  last cycle of the current phase
module cfg_phase_timer #(
  parameter int unsigned CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] load_value,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/driver_cfg_writer.sv
// driver_cfg_writer
//   Drives the asynchronous config bus that driver_core synchronises. A
//   timed command (MEM_WR, DOT_WR, SEL_WR) presents address/data for
//   SETUP_CYCLES, pulls one active-low strobe for STROBE_CYCLES, then holds
//   address/data for HOLD_CYCLES so the receiver's synchronisers see stable
//   values. SET_CTRL updates the static control levels and runs SETUP+HOLD
//   with no strobe. NOP and reserved ops are consumed in one cycle; reserved
//   ops pulse cmd_err on the following cycle.
// Ports
//   clock, reset                 clock_a clock, async active-high reset
//   cmd_valid / cmd_ready        command handshake (ready only when idle)
//   cmd_op, cmd_addr, cmd_col,
//   cmd_sel_addr, cmd_data,
//   cmd_mask                     command fields
//   mask_select_a .. data_in_a   registered bus fields
//   mem_write_n_a,
//   mem_dot_write_n_a,
//   mem_sel_write_n_a            registered active-low write strobes
//   row_col_select_a,
//   output_active_a,
//   inverter_select_a            registered static control levels
//   cmd_err                      one-cycle pulse after a reserved op
module driver_cfg_writer
  import driver_cfg_writer_pkg::*;
#(
  parameter int unsigned MEM_ADDRESS_LENGTH = 6,
  parameter int unsigned SETUP_CYCLES       = 4,
  parameter int unsigned STROBE_CYCLES      = 4,
  parameter int unsigned HOLD_CYCLES        = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [MEM_ADDRESS_LENGTH-1:0] cmd_addr,
  input  logic [MEM_ADDRESS_LENGTH-1:0] cmd_col,
  input  logic [MEM_ADDRESS_LENGTH-1:0] cmd_sel_addr,
  input  logic [15:0]                   cmd_data,
  input  logic [2:0]                    cmd_mask,
  output logic [2:0]                    mask_select_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] mem_address_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] row_select_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] col_select_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] mem_sel_col_address_a,
  output logic [15:0]                   data_in_a,
  output logic                          mem_write_n_a,
  output logic                          mem_dot_write_n_a,
  output logic                          mem_sel_write_n_a,
  output logic                          row_col_select_a,
  output logic                          output_active_a,
  output logic                          inverter_select_a,
  output logic                          cmd_err
);

  localparam int unsigned MAX_PHASE = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int unsigned CW        = $clog2(MAX_PHASE + 1);

  wr_state_t   state;
  wr_state_t   state_nxt;
  strobe_sel_t strobe_sel;
  logic [2:0]  strobe_n_nxt;
  logic        accept;
  logic        timer_start;
  logic [CW-1:0] timer_load;
  logic        timer_done;

  assign accept = cmd_valid && cmd_ready;

  cfg_phase_timer #(
    .CW (CW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .start      (timer_start),
    .load_value (timer_load),
    .done       (timer_done)
  );

  // Next-state and phase-timer load. The timer is reloaded on the same edge
  // that enters each phase, so every phase lasts exactly its parameter.
  always_comb begin
    state_nxt   = state;
    timer_start = 1'b0;
    timer_load  = '0;
    case (state)
      ST_IDLE: begin
        if (accept && op_is_timed(cmd_op)) begin
          state_nxt   = ST_SETUP;
          timer_start = 1'b1;
          timer_load  = CW'(SETUP_CYCLES);
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          timer_start = 1'b1;
          if (strobe_sel != '0) begin
            state_nxt  = ST_STROBE;
            timer_load = CW'(STROBE_CYCLES);
          end else begin
            // SET_CTRL: no strobe phase.
            state_nxt  = ST_HOLD;
            timer_load = CW'(HOLD_CYCLES);
          end
        end
      end
      ST_STROBE: begin
        if (timer_done) begin
          state_nxt   = ST_HOLD;
          timer_start = 1'b1;
          timer_load  = CW'(HOLD_CYCLES);
        end
      end
      ST_HOLD: begin
        if (timer_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and ready are registered from next-state decode so the bus sees
  // clean single-flop transitions; strobe_sel is one-hot, so at most one
  // strobe is ever low.
  always_comb begin
    strobe_n_nxt = '1;
    if (state_nxt == ST_STROBE) begin
      strobe_n_nxt = ~strobe_sel;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= ST_IDLE;
      cmd_ready             <= 1'b1;
      strobe_sel            <= '0;
      mem_write_n_a         <= 1'b1;
      mem_dot_write_n_a     <= 1'b1;
      mem_sel_write_n_a     <= 1'b1;
      mask_select_a         <= '0;
      mem_address_a         <= '0;
      row_select_a          <= '0;
      col_select_a          <= '0;
      mem_sel_col_address_a <= '0;
      data_in_a             <= '0;
      row_col_select_a      <= 1'b0;
      output_active_a       <= 1'b0;
      inverter_select_a     <= 1'b0;
      cmd_err               <= 1'b0;
    end else begin
      state             <= state_nxt;
      cmd_ready         <= (state_nxt == ST_IDLE);
      mem_write_n_a     <= strobe_n_nxt[0];
      mem_dot_write_n_a <= strobe_n_nxt[1];
      mem_sel_write_n_a <= strobe_n_nxt[2];
      cmd_err           <= accept && op_is_reserved(cmd_op);

      if (accept) begin
        strobe_sel <= op_strobe(cmd_op);
        // Only the fields an op uses are captured; the rest keep their values.
        case (cmd_op)
          OP_MEM_WR, OP_DOT_WR: begin
            mem_address_a <= cmd_addr;
            data_in_a     <= cmd_data;
            mask_select_a <= cmd_mask;
          end
          OP_SEL_WR: begin
            row_select_a          <= cmd_addr;
            col_select_a          <= cmd_col;
            mem_sel_col_address_a <= cmd_sel_addr;
          end
          OP_SET_CTRL: begin
            inverter_select_a <= cmd_data[2];
            output_active_a   <= cmd_data[1];
            row_col_select_a  <= cmd_data[0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_driver_cfg_writer.sv
// tb_driver_cfg_writer
//   Directed plus randomized checks of driver_cfg_writer against a
//   behavioural model: expected bus contents are shadow values updated per
//   accepted command, and strobe/ready/err timing is computed from the phase
//   lengths with plain arithmetic on the cycle index after acceptance.
module tb_driver_cfg_writer;

  localparam int MAL = 6;
  localparam int S   = 4;
  localparam int ST  = 4;
  localparam int H   = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [MAL-1:0] cmd_addr, cmd_col, cmd_sel_addr;
  logic [15:0]    cmd_data;
  logic [2:0]     cmd_mask;
  logic [2:0]     mask_select_a;
  logic [MAL-1:0] mem_address_a, row_select_a, col_select_a, mem_sel_col_address_a;
  logic [15:0]    data_in_a;
  logic           mem_write_n_a, mem_dot_write_n_a, mem_sel_write_n_a;
  logic           row_col_select_a, output_active_a, inverter_select_a;
  logic           cmd_err;

  driver_cfg_writer #(
    .MEM_ADDRESS_LENGTH (MAL),
    .SETUP_CYCLES       (S),
    .STROBE_CYCLES      (ST),
    .HOLD_CYCLES        (H)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_addr              (cmd_addr),
    .cmd_col               (cmd_col),
    .cmd_sel_addr          (cmd_sel_addr),
    .cmd_data              (cmd_data),
    .cmd_mask              (cmd_mask),
    .mask_select_a         (mask_select_a),
    .mem_address_a         (mem_address_a),
    .row_select_a          (row_select_a),
    .col_select_a          (col_select_a),
    .mem_sel_col_address_a (mem_sel_col_address_a),
    .data_in_a             (data_in_a),
    .mem_write_n_a         (mem_write_n_a),
    .mem_dot_write_n_a     (mem_dot_write_n_a),
    .mem_sel_write_n_a     (mem_sel_write_n_a),
    .row_col_select_a      (row_col_select_a),
    .output_active_a       (output_active_a),
    .inverter_select_a     (inverter_select_a),
    .cmd_err               (cmd_err)
  );

  always #5 clock = ~clock;

  int unsigned asserts = 0;
  int unsigned fails   = 0;
  longint      last_acc = 0;

  // Shadow of the bus/control registers.
  logic [MAL-1:0] m_addr, m_row, m_col, m_sel;
  logic [15:0]    m_data;
  logic [2:0]     m_mask;
  logic           m_rc, m_oa, m_inv;

  task automatic model_clear();
    m_addr = '0; m_row = '0; m_col = '0; m_sel = '0;
    m_data = '0; m_mask = '0; m_rc = 1'b0; m_oa = 1'b0; m_inv = 1'b0;
  endtask

  function automatic logic [63:0] dut_bus();
    return 64'({mem_address_a, row_select_a, col_select_a, mem_sel_col_address_a,
                data_in_a, mask_select_a, row_col_select_a, output_active_a,
                inverter_select_a});
  endfunction

  function automatic logic [63:0] model_bus();
    return 64'({m_addr, m_row, m_col, m_sel, m_data, m_mask, m_rc, m_oa, m_inv});
  endfunction

  function automatic logic [63:0] dut_strobes();
    return 64'({mem_sel_write_n_a, mem_dot_write_n_a, mem_write_n_a});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command from a negedge with the writer idle, then check every
  // cycle of its occupancy. abort_k >= 0 asserts reset at that cycle index;
  // gap > 0 checks the clock count since the previous accept; b2b returns on
  // the first ready cycle so the caller can issue the next command at once.
  task automatic run_cmd(input logic [2:0] op, input logic [MAL-1:0] addr,
                         input logic [MAL-1:0] col, input logic [MAL-1:0] sel,
                         input logic [15:0] data, input logic [2:0] mask,
                         input int abort_k, input int gap, input bit b2b);
    int         total;
    int         last_k;
    logic [2:0] sb;
    logic [2:0] exp_str;
    longint     t_acc;
    chk("ready_before_cmd", 64'(cmd_ready), 64'(1));
    cmd_op = op; cmd_addr = addr; cmd_col = col; cmd_sel_addr = sel;
    cmd_data = data; cmd_mask = mask; cmd_valid = 1'b1;
    @(posedge clock);
    t_acc = $time;
    if (gap > 0) chk("accept_gap", 64'((t_acc - last_acc) / 10), 64'(gap));
    last_acc = t_acc;

    sb = 3'b000;
    total = 0;
    case (op)
      3'd1: begin m_addr = addr; m_data = data; m_mask = mask; sb = 3'b001; total = S + ST + H; end
      3'd2: begin m_addr = addr; m_data = data; m_mask = mask; sb = 3'b010; total = S + ST + H; end
      3'd3: begin m_row = addr; m_col = col; m_sel = sel; sb = 3'b100; total = S + ST + H; end
      3'd4: begin m_inv = data[2]; m_oa = data[1]; m_rc = data[0]; total = S + H; end
      default: ;
    endcase

    @(negedge clock);
    last_k = b2b ? total : total + 1;
    for (int k = 0; k <= last_k; k++) begin
      if (k == abort_k) begin
        cmd_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_clear();
        chk("abort_strobes", dut_strobes(), 64'(3'b111));
        chk("abort_bus", dut_bus(), model_bus());
        chk("abort_ready", 64'(cmd_ready), 64'(1));
        @(negedge clock);
        reset = 1'b0;
        return;
      end
      exp_str = (sb != 3'b000 && k >= S && k < S + ST) ? ~sb : 3'b111;
      chk("strobes", dut_strobes(), 64'(exp_str));
      chk("ready", 64'(cmd_ready), 64'(k >= total));
      chk("cmd_err", 64'(cmd_err), 64'(op >= 3'd5 && k == 0));
      chk("bus", dut_bus(), model_bus());
      if (k < total) begin
        // Busy: random traffic on the command port must be ignored.
        cmd_valid    = 1'($urandom_range(0, 1));
        cmd_op       = 3'($urandom_range(0, 7));
        cmd_addr     = MAL'($urandom);
        cmd_col      = MAL'($urandom);
        cmd_sel_addr = MAL'($urandom);
        cmd_data     = 16'($urandom);
        cmd_mask     = 3'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (k < last_k) @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_col = '0;
    cmd_sel_addr = '0; cmd_data = '0; cmd_mask = '0;
    model_clear();
    @(negedge clock);
    @(negedge clock);
    chk("reset_strobes", dut_strobes(), 64'(3'b111));
    chk("reset_bus", dut_bus(), model_bus());
    chk("reset_ready", 64'(cmd_ready), 64'(1));
    chk("reset_err", 64'(cmd_err), 64'(0));
    reset = 1'b0;
    @(negedge clock);

    // MEM_WR with the reference pattern.
    run_cmd(3'd1, 6'h05, 6'h00, 6'h00, 16'hA5A5, 3'b101, -1, 0, 1'b0);
    // SEL_WR then DOT_WR issued on the first ready cycle.
    run_cmd(3'd3, 6'd3, 6'd7, 6'd9, 16'h1234, 3'b010, -1, 0, 1'b1);
    run_cmd(3'd2, 6'h2A, 6'h11, 6'h22, 16'h5A0F, 3'b011, -1, S + ST + H + 1, 1'b0);
    // SET_CTRL inv=1, out_act=1, row_col=0.
    run_cmd(3'd4, 6'h3F, 6'h3F, 6'h3F, 16'hFFF6, 3'b111, -1, 0, 1'b0);
    // Reserved op and NOP.
    run_cmd(3'd6, 6'h15, 6'h16, 6'h17, 16'hBEEF, 3'b001, -1, 0, 1'b0);
    run_cmd(3'd0, 6'h01, 6'h02, 6'h03, 16'hCAFE, 3'b110, -1, 0, 1'b0);
    // Reset during the strobe phase, then a normal write.
    run_cmd(3'd1, 6'h33, 6'h00, 6'h00, 16'h0F0F, 3'b100, S + 1, 0, 1'b0);
    @(negedge clock);
    run_cmd(3'd1, 6'h0C, 6'h00, 6'h00, 16'h7E81, 3'b011, -1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_cmd(3'($urandom_range(0, 7)), MAL'($urandom), MAL'($urandom), MAL'($urandom),
              16'($urandom), 3'($urandom), -1, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
